// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA controller.
// Build option OAM_DMA_ECHO_MIRROR_EN folds echo-RAM source pages onto WRAM.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
  localparam logic [15:0] OAM_BASE_ADDR = 16'hFE00;
  localparam int unsigned OAM_SIZE      = 160;
  localparam logic [7:0]  ECHO_PAGE_LO  = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET   = 8'h20;

  // Source page actually presented on the bus; the register keeps the raw value.
  function automatic logic [7:0] eff_page(input logic [7:0] page);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    return (page >= ECHO_PAGE_LO) ? (page - ECHO_OFFSET) : page;
`else
    return page;
`endif
  endfunction

endpackage

// File: rtl/oam_dma_ctrl_oam_port_arb.sv
// OAM port arbiter: CPU pass-through when idle, DMA ownership with CPU
// writes dropped and reads masked to 8'hFF while a transfer is active.
module oam_port_arb
  import oam_dma_pkg::*;
(
  input  logic        dma_active_i,
  input  logic [15:0] dma_a_i,
  input  logic        dma_wr_i,
  input  logic [7:0]  dma_din_i,
  input  logic [15:0] cpu_oam_a_i,
  input  logic        cpu_oam_wr_i,
  input  logic [7:0]  cpu_oam_din_i,
  output logic [7:0]  cpu_oam_dout_o,
  output logic [15:0] oam_a_o,
  output logic        oam_wr_o,
  output logic [7:0]  oam_din_o,
  input  logic [7:0]  oam_dout_i
);

  always_comb begin
    oam_a_o        = cpu_oam_a_i;
    oam_wr_o       = cpu_oam_wr_i;
    oam_din_o      = cpu_oam_din_i;
    cpu_oam_dout_o = oam_dout_i;
    if (dma_active_i) begin
      oam_a_o        = dma_a_i;
      oam_wr_o       = dma_wr_i;
      oam_din_o      = dma_din_i;
      cpu_oam_dout_o = '1;
    end
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// Game Boy OAM DMA controller: 0xFF46 write starts a NUM_BYTES copy from
// {page, 8'h00} into OAM. Build option: OAM_DMA_ECHO_MIRROR_EN.
module oam_dma_ctrl
  import oam_dma_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = OAM_SIZE,
  parameter int unsigned START_DELAY = 1,
  parameter logic [15:0] OAM_BASE    = OAM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic        src_req,
  output logic [15:0] src_a,
  input  logic        src_ack,
  input  logic [7:0]  src_din,
  input  logic [15:0] cpu_oam_a,
  input  logic        cpu_oam_wr,
  input  logic [7:0]  cpu_oam_din,
  output logic [7:0]  cpu_oam_dout,
  output logic [15:0] oam_a,
  output logic        oam_wr,
  output logic [7:0]  oam_din,
  input  logic [7:0]  oam_dout,
  output logic        dma_active
);

  localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
  localparam logic [7:0]  LAST_IDX = 8'(NUM_BYTES - 1);

  dma_state_t    state_q, state_d;
  logic [7:0]    page_q, page_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    lat_q, lat_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          act_q, act_d;

  logic [15:0]   dma_a;
  logic          dma_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      dly_q   <= '0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      dly_q   <= dly_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    dly_d   = dly_q;
    act_d   = act_q;
    // A register write restarts from any state, overriding the current step.
    if (reg_wr) begin
      page_d  = reg_din;
      idx_d   = '0;
      dly_d   = DW'(START_DELAY);
      state_d = (START_DELAY == 0) ? READ : DELAY;
      act_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        DELAY: begin
          if (dly_q <= DW'(1)) state_d = READ;
          else                 dly_d   = dly_q - DW'(1);
        end
        READ: begin
          if (src_ack) begin
            lat_d   = src_din;
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            act_d   = 1'b0;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = READ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    src_req = (state_q == READ);
    src_a   = src_req ? {eff_page(page_q), idx_q} : '0;
    dma_wr  = (state_q == WRITE) && !reg_wr;
    dma_a   = OAM_BASE + {8'h00, idx_q};
  end

  assign reg_dout   = page_q;
  assign dma_active = act_q;

  oam_port_arb u_arb (
    .dma_active_i   (act_q),
    .dma_a_i        (dma_a),
    .dma_wr_i       (dma_wr),
    .dma_din_i      (lat_q),
    .cpu_oam_a_i    (cpu_oam_a),
    .cpu_oam_wr_i   (cpu_oam_wr),
    .cpu_oam_din_i  (cpu_oam_din),
    .cpu_oam_dout_o (cpu_oam_dout),
    .oam_a_o        (oam_a),
    .oam_wr_o       (oam_wr),
    .oam_din_o      (oam_din),
    .oam_dout_i     (oam_dout)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: idle pass-through vector table plus
// directed transfer, restart, CPU-masking, echo page and async reset sequences.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_wr;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic        src_req;
  logic [15:0] src_a;
  logic        src_ack;
  logic [7:0]  src_din;
  logic [15:0] cpu_oam_a;
  logic        cpu_oam_wr;
  logic [7:0]  cpu_oam_din;
  logic [7:0]  cpu_oam_dout;
  logic [15:0] oam_a;
  logic        oam_wr;
  logic [7:0]  oam_din;
  logic [7:0]  oam_dout;
  logic        dma_active;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  oam_dma_ctrl #(.NUM_BYTES(160), .START_DELAY(1), .OAM_BASE(16'hFE00)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_wr       (reg_wr),
    .reg_din      (reg_din),
    .reg_dout     (reg_dout),
    .src_req      (src_req),
    .src_a        (src_a),
    .src_ack      (src_ack),
    .src_din      (src_din),
    .cpu_oam_a    (cpu_oam_a),
    .cpu_oam_wr   (cpu_oam_wr),
    .cpu_oam_din  (cpu_oam_din),
    .cpu_oam_dout (cpu_oam_dout),
    .oam_a        (oam_a),
    .oam_wr       (oam_wr),
    .oam_din      (oam_din),
    .oam_dout     (oam_dout),
    .dma_active   (dma_active)
  );

  // Source memory model: page C1 byte i = i ^ 8'h5A, other pages differ.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] ^ 8'hC1);
  endfunction

  int ack_dly = 0;
  int wait_cnt = 0;
  always @(posedge clk) begin
    if (!src_req || src_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end
  assign src_ack = src_req && (wait_cnt >= ack_dly);
  assign src_din = src_byte(src_a);

  logic [7:0] oam_mem [0:255];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (oam_wr && oam_a[15:8] == 8'hFE) begin
      oam_mem[oam_a[7:0]] <= oam_din;
      wr_cnt <= wr_cnt + 1;
    end
  end
  assign oam_dout = oam_mem[oam_a[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_dma(input logic [7:0] p);
    reg_din = p;
    reg_wr  = 1'b1;
    @(negedge clk);
    reg_wr  = 1'b0;
  endtask

  task automatic wait_writes(input string name, input int base, input int n);
    int k = 0;
    while ((wr_cnt - base) < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if ((wr_cnt - base) < n) check(name, 32'(wr_cnt - base), 32'(n));
  endtask

  task automatic run_idle(input int start, output int cyc, output int unstable);
    logic        prev_req;
    logic [15:0] prev_a;
    cyc = start;
    unstable = 0;
    prev_req = src_req;
    prev_a = src_a;
    while (dma_active && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (prev_req && src_req && src_a !== prev_a) unstable++;
      prev_req = src_req;
      prev_a = src_a;
    end
  endtask

  task automatic check_oam(input string name, input logic [7:0] page);
    int bad = 0;
    for (int i = 0; i < 160; i++)
      if (oam_mem[i] !== src_byte({page, 8'(i)})) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic        wr;
    logic [7:0]  din;
    logic [15:0] exp_a;
    logic        exp_wr;
    logic [7:0]  exp_din;
    logic        chk_dout;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int base, base2, cyc, unst, k, bad;
    logic [7:0] echo_pg;

    vecs[0] = '{16'hFE05, 1'b1, 8'h3C, 16'hFE05, 1'b1, 8'h3C, 1'b0, 8'h00};
    vecs[1] = '{16'hFE05, 1'b0, 8'h00, 16'hFE05, 1'b0, 8'h00, 1'b1, 8'h3C};
    vecs[2] = '{16'hFE9F, 1'b1, 8'hA5, 16'hFE9F, 1'b1, 8'hA5, 1'b0, 8'h00};
    vecs[3] = '{16'hFE9F, 1'b0, 8'h11, 16'hFE9F, 1'b0, 8'h11, 1'b1, 8'hA5};
    vecs[4] = '{16'hFE05, 1'b0, 8'hFF, 16'hFE05, 1'b0, 8'hFF, 1'b1, 8'h3C};
    vecs[5] = '{16'h1234, 1'b0, 8'h42, 16'h1234, 1'b0, 8'h42, 1'b0, 8'h00};

    rst = 1'b1; reg_wr = 1'b0; reg_din = '0;
    cpu_oam_a = 16'hFE00; cpu_oam_wr = 1'b0; cpu_oam_din = '0;
    #1;
    check("rst_dma_active", 32'(dma_active), 32'd0);
    check("rst_src_req", 32'(src_req), 32'd0);
    check("rst_src_a", 32'(src_a), 32'd0);
    check("rst_reg_dout", 32'(reg_dout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle pass-through table; each write lands at the posedge before the next vector.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cpu_oam_a = vecs[i].a; cpu_oam_wr = vecs[i].wr; cpu_oam_din = vecs[i].din;
      #1;
      check($sformatf("idle_oam_a_%0d", i), 32'(oam_a), 32'(vecs[i].exp_a));
      check($sformatf("idle_oam_wr_%0d", i), 32'(oam_wr), 32'(vecs[i].exp_wr));
      check($sformatf("idle_oam_din_%0d", i), 32'(oam_din), 32'(vecs[i].exp_din));
      if (vecs[i].chk_dout)
        check($sformatf("idle_dout_%0d", i), 32'(cpu_oam_dout), 32'(vecs[i].exp_dout));
    end
    @(negedge clk);
    cpu_oam_wr = 1'b0;

    // Basic transfer, ack tied high.
    @(negedge clk);
    base = wr_cnt;
    start_dma(8'hC1);
    check("t1_delay_noreq", 32'(src_req), 32'd0);
    check("t1_active", 32'(dma_active), 32'd1);
    @(negedge clk);
    check("t1_first_req", 32'(src_req), 32'd1);
    check("t1_first_src_a", 32'(src_a), 32'hC100);
    run_idle(2, cyc, unst);
    check("t1_cycles", 32'(cyc), 32'd322);
    check("t1_writes", 32'(wr_cnt - base), 32'd160);
    check_oam("t1_oam_data", 8'hC1);

    // Ack delayed 3 cycles per byte.
    ack_dly = 3;
    @(negedge clk);
    base = wr_cnt;
    start_dma(8'hC2);
    run_idle(1, cyc, unst);
    check("t2_cycles", 32'(cyc), 32'd802);
    check("t2_src_a_stable", 32'(unst), 32'd0);
    check("t2_writes", 32'(wr_cnt - base), 32'd160);
    check_oam("t2_oam_data", 8'hC2);
    ack_dly = 0;

    // CPU write dropped and reads masked mid-transfer.
    @(negedge clk);
    cpu_oam_a = 16'hFE10;
    base = wr_cnt;
    start_dma(8'hC4);
    wait_writes("t3_wait50", base, 50);
    cpu_oam_wr = 1'b1; cpu_oam_din = 8'h77;
    #1;
    check("t3_masked_dout", 32'(cpu_oam_dout), 32'hFF);
    @(negedge clk);
    cpu_oam_wr = 1'b0;
    run_idle(1, cyc, unst);
    check("t3_writes", 32'(wr_cnt - base), 32'd160);
    check("t3_oam10_kept", 32'(oam_mem[8'h10]), 32'(src_byte(16'hC410)));
    #1;
    check("t3_dout_after", 32'(cpu_oam_dout), 32'(src_byte(16'hC410)));

    // Restart during a WRITE cycle at byte 80.
    @(negedge clk);
    base = wr_cnt;
    start_dma(8'hC5);
    wait_writes("t4_wait80", base, 80);
    k = 0;
    while (!oam_wr && k < 20) begin @(negedge clk); k++; end
    check("t4_in_write", 32'(oam_wr), 32'd1);
    reg_din = 8'hD0; reg_wr = 1'b1;
    #1;
    check("t4_wr_suppressed", 32'(oam_wr), 32'd0);
    base2 = wr_cnt;
    @(negedge clk);
    reg_wr = 1'b0;
    k = 0;
    while (!src_req && k < 20) begin @(negedge clk); k++; end
    check("t4_restart_src_a", 32'(src_a), 32'hD000);
    k = 0;
    while (!oam_wr && k < 20) begin @(negedge clk); k++; end
    check("t4_restart_oam_a", 32'(oam_a), 32'hFE00);
    check("t4_restart_oam_din", 32'(oam_din), 32'(src_byte(16'hD000)));
    run_idle(1, cyc, unst);
    check("t4_writes", 32'(wr_cnt - base2), 32'd160);
    check_oam("t4_oam_data", 8'hD0);
    check("t4_reg_dout", 32'(reg_dout), 32'hD0);

    // Echo-RAM page.
`ifdef OAM_DMA_ECHO_MIRROR_EN
    echo_pg = 8'hC3;
`else
    echo_pg = 8'hE3;
`endif
    @(negedge clk);
    start_dma(8'hE3);
    @(negedge clk);
    check("t5_src_a", 32'(src_a), 32'({echo_pg, 8'h00}));
    check("t5_reg_dout", 32'(reg_dout), 32'hE3);
    run_idle(2, cyc, unst);
    check_oam("t5_oam_data", echo_pg);

    // Asynchronous reset at byte 100.
    @(negedge clk);
    cpu_oam_a = 16'hFE20;
    base = wr_cnt;
    start_dma(8'hC7);
    wait_writes("t6_wait100", base, 100);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_active", 32'(dma_active), 32'd0);
    check("t6_rst_src_req", 32'(src_req), 32'd0);
    check("t6_rst_oam_wr", 32'(oam_wr), 32'd0);
    check("t6_rst_oam_a", 32'(oam_a), 32'hFE20);
    check("t6_rst_dout", 32'(cpu_oam_dout), 32'(src_byte(16'hC720)));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = wr_cnt;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (dma_active || src_req) bad++;
    end
    check("t6_stays_idle", 32'(bad), 32'd0);
    check("t6_no_writes", 32'(wr_cnt - base), 32'd0);
    check("t6_reg_dout", 32'(reg_dout), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
